div_seq: RTL

//  Multicycle signed integer divider; the inverse of the CLA add path. It shares
//  the same ctrl/data handshake as the multiplier and sits in the MULT/DIV unit

---
 rtl/div_pkg.sv | 16 +
 rtl/div_seq_if.sv | 33 +++
 rtl/sub_cla.sv | 80 ++++++++
 rtl/div_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings and default width.
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DIV_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CALC = S_CALC,
    ST_DONE = S_DONE
  } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// Divider ctrl/data handshake bundle, shared with the multiplier.
// The data_remainder signal exists only when DIV_REMAINDER_EN is defined.
interface div_seq_if import div_pkg::*; #(
  parameter int WIDTH = DIV_W_DEFAULT
) ();

  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] data_remainder;
`endif

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
`ifdef DIV_REMAINDER_EN
    , input data_remainder
`endif
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
`ifdef DIV_REMAINDER_EN
    , output data_remainder
`endif
  );

endinterface

// File: rtl/sub_cla.sv
// Combinational subtractor x - y = x + ~y + 1, built from 8-bit carry-lookahead blocks.
// Operands are zero-padded to whole blocks with at least one spare bit, so the
// carry out of bit N-1 appears as sum bit N.

module cla_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       cc;
  logic       pr;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is formed directly from generate/propagate terms and cin.
  always_comb begin
    c    = '0;
    cc   = 1'b0;
    pr   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      cc = g[i];
      pr = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc = cc | (pr & g[j]);
        pr = pr & p[j];
      end
      c[i+1] = cc | (pr & cin);
    end
  end

  assign s    = p ^ c[7:0];
  assign cout = c[8];

endmodule

module sub_cla #(
  parameter int N = 33
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int NB = (N + 9) / 8;
  localparam int NP = NB * 8;

  logic [NP-1:0] a_pad;
  logic [NP-1:0] b_pad;
  logic [NP-1:0] s_pad;
  logic [NB:0]   c;
  logic          unused_pad;

  assign a_pad = {{(NP-N){1'b0}}, x};
  assign b_pad = {{(NP-N){1'b0}}, ~y};
  assign c[0]  = 1'b1;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    cla_8 u_cla (
      .a    (a_pad[8*i +: 8]),
      .b    (b_pad[8*i +: 8]),
      .cin  (c[i]),
      .s    (s_pad[8*i +: 8]),
      .cout (c[i+1])
    );
  end

  assign diff       = s_pad[N-1:0];
  assign borrow     = ~s_pad[N];
  assign unused_pad = ^{c[NB], s_pad[NP-1:N+1]};

endmodule

// File: rtl/div_seq.sv
// Multicycle signed restoring divider, one quotient bit per cycle.
// Optional feature: define DIV_REMAINDER_EN to expose data_remainder.
module div_seq import div_pkg::*; #(
  parameter int WIDTH = DIV_W_DEFAULT,
  parameter int CNT_W = 6
) (
  input  logic     clock,
  input  logic     resetn,
  div_seq_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             exc_q;
  logic             rdy_q;
  logic             exc_pend_q;
  logic [WIDTH-1:0] remo_q;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_q;
  logic             sign_a_q;

  logic             start;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             special;
  logic [WIDTH-1:0] spec_q;

  logic [WIDTH-1:0] neg_a_y;
  logic [WIDTH-1:0] neg_a;
  logic             neg_a_bw;
  logic [WIDTH-1:0] neg_b_y;
  logic [WIDTH-1:0] neg_b;
  logic             neg_b_bw;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   step_diff;
  logic             step_bw;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] rem_d;
  logic             unused_bits;

  assign start = bus.ctrl_DIV;
  assign a_i   = bus.data_operandA;
  assign b_i   = bus.data_operandB;

  // Divide-by-zero yields 0, the single overflowing case yields min_int.
  assign special = (b_i == '0) || ((a_i == MIN_INT) && (b_i == '1));
  assign spec_q  = (b_i == '0) ? '0 : MIN_INT;

  // Shared negators: operand magnitudes on a start, final sign fix-up otherwise.
  assign neg_a_y = start ? a_i : q_q;
  assign neg_b_y = start ? b_i : rem_q;

  sub_cla #(.N(WIDTH)) u_neg_a (
    .x      ({WIDTH{1'b0}}),
    .y      (neg_a_y),
    .diff   (neg_a),
    .borrow (neg_a_bw)
  );

  sub_cla #(.N(WIDTH)) u_neg_b (
    .x      ({WIDTH{1'b0}}),
    .y      (neg_b_y),
    .diff   (neg_b),
    .borrow (neg_b_bw)
  );

  assign abs_a = a_i[WIDTH-1] ? neg_a : a_i;
  assign abs_b = b_i[WIDTH-1] ? neg_b : b_i;

  // Restoring step: trial-subtract the divisor from the shifted partial remainder.
  assign rem_shift = {rem_q, q_q[WIDTH-1]};

  sub_cla #(.N(WIDTH+1)) u_step (
    .x      (rem_shift),
    .y      ({1'b0, dvs_q}),
    .diff   (step_diff),
    .borrow (step_bw)
  );

  assign q_d   = {q_q[WIDTH-2:0], ~step_bw};
  assign rem_d = step_bw ? rem_shift[WIDTH-1:0] : step_diff[WIDTH-1:0];

  // Control FSM, iteration counter and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      res_q      <= '0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
      exc_pend_q <= 1'b0;
      remo_q     <= '0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        state_q    <= special ? ST_DONE : ST_CALC;
        cnt_q      <= CNT_W'(WIDTH);
        res_q      <= '0;
        exc_q      <= 1'b0;
        remo_q     <= '0;
        exc_pend_q <= special;
      end else begin
        case (state_q)
          ST_CALC: begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= ST_DONE;
          end
          ST_DONE: begin
            res_q   <= (sign_q && !exc_pend_q) ? neg_a : q_q;
            exc_q   <= exc_pend_q;
            remo_q  <= exc_pend_q ? '0 : (sign_a_q ? neg_b : rem_q);
            rdy_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Datapath registers: operand latch on start, one shift/subtract per CALC cycle.
  always_ff @(posedge clock) begin
    if (start) begin
      q_q      <= special ? spec_q : abs_a;
      rem_q    <= '0;
      dvs_q    <= abs_b;
      sign_q   <= special ? 1'b0 : (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      sign_a_q <= a_i[WIDTH-1];
    end else if (state_q == ST_CALC) begin
      q_q   <= q_d;
      rem_q <= rem_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

`ifdef DIV_REMAINDER_EN
  assign bus.data_remainder = remo_q;
  assign unused_bits = ^{neg_a_bw, neg_b_bw, step_diff[WIDTH]};
`else
  assign unused_bits = ^{neg_a_bw, neg_b_bw, step_diff[WIDTH], remo_q};
`endif

endmodule
